// File: rtl/demux_1to4.sv
// demux_1to4: registered 1:4 demultiplexer with frame collection.
// Symbols arriving on a shared bus are steered into four held channels;
// once all four channels hold fresh data the frame is presented on
// frame_valid and the block stalls (in_ready=0) until frame_ack.
// Optional feature macro: DEMUX_AUTO_SEL_EN -- when defined, the channel
// comes from an internal wrapping pointer and sel is ignored.
module demux_1to4 #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] D,
    input  logic [1:0]   sel,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] Y0,
    output logic [W-1:0] Y1,
    output logic [W-1:0] Y2,
    output logic [W-1:0] Y3,
    output logic [3:0]   Y_valid,
    output logic         frame_valid,
    input  logic         frame_ack,
    output logic         ovr
);

    typedef enum logic {
        COLLECT = 1'b0,
        FULL    = 1'b1
    } state_t;

    state_t         state;
    state_t         state_next;
    logic [W-1:0]   y_reg [4];
    logic [3:0]     y_valid_reg;
    logic           ovr_reg;
    logic           accept;
    logic [1:0]     ch;
    logic [3:0]     ch_onehot;
    logic           frame_done;

    // Accept depends on state only through in_ready, so there is no
    // combinational path from in_valid back to in_ready.
    assign accept     = in_valid & in_ready;
    assign ch_onehot  = 4'b0001 << ch;
    // Completion is decided purely on which channels are valid, so an
    // overwrite never counts toward filling the frame.
    assign frame_done = ((y_valid_reg | ch_onehot) == 4'b1111);

`ifdef DEMUX_AUTO_SEL_EN
    logic [1:0] ptr;
    logic       unused_sel;

    assign ch         = ptr;
    assign unused_sel = ^sel;

    // Fill pointer: advances on every accept and wraps 3->0, which puts it
    // back at 0 exactly when a frame completes, so frame_ack leaves it alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= 2'd0;
        end else if (accept) begin
            ptr <= ptr + 2'd1;
        end
    end
`else
    assign ch = sel;
`endif

    // State register with synchronous reset taking priority over all inputs.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of its neighbours.
        if (rst) begin
            state <= COLLECT;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: fill to FULL on the completing accept, drain on ack.
    always_comb begin
        // NOTE: default assignment first so no path leaves state_next
        // unassigned, which would otherwise infer a latch.
        state_next = state;
        unique case (state)
            COLLECT: if (accept && frame_done) state_next = FULL;
            FULL:    if (frame_ack)            state_next = COLLECT;
            default: state_next = COLLECT;
        endcase
    end

    // Output logic: handshake and frame flags are functions of state only.
    always_comb begin
        in_ready    = 1'b0;
        frame_valid = 1'b0;
        unique case (state)
            COLLECT: in_ready    = 1'b1;
            FULL:    frame_valid = 1'b1;
            default: in_ready    = 1'b0;
        endcase
    end

    // Channel datapath: write on accept, flag overwrites, clear valids on ack.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the channel registers are real outputs with defined
            // reset values, so they are cleared here rather than left as
            // uninitialised storage.
            for (int i = 0; i < 4; i++) begin
                y_reg[i] <= '0;
            end
            y_valid_reg <= 4'b0000;
            ovr_reg     <= 1'b0;
        end else begin
            ovr_reg <= 1'b0;
            if (accept) begin
                y_reg[ch] <= D;
                if (y_valid_reg[ch]) begin
                    ovr_reg <= 1'b1;
                end else begin
                    y_valid_reg[ch] <= 1'b1;
                end
            end else if (state == FULL && frame_ack) begin
                // Data is kept; only the freshness flags are released.
                y_valid_reg <= 4'b0000;
            end
        end
    end

    assign Y0      = y_reg[0];
    assign Y1      = y_reg[1];
    assign Y2      = y_reg[2];
    assign Y3      = y_reg[3];
    assign Y_valid = y_valid_reg;
    assign ovr     = ovr_reg;

endmodule

// File: tb/tb_demux_1to4.sv
// Testbench for demux_1to4: directed steps from the test plan followed by
// randomized traffic, all checked against a behavioural frame model.
// Honours DEMUX_AUTO_SEL_EN the same way the design does.
module tb_demux_1to4;

    localparam int W = 2;

    logic         clk;
    logic         rst;
    logic [W-1:0] D;
    logic [1:0]   sel;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] Y0;
    logic [W-1:0] Y1;
    logic [W-1:0] Y2;
    logic [W-1:0] Y3;
    logic [3:0]   Y_valid;
    logic         frame_valid;
    logic         frame_ack;
    logic         ovr;

    int total = 0;
    int bad   = 0;

    // Behavioural model: channel contents, per-channel freshness, frame flag.
    logic [W-1:0] m_y [4];
    bit           m_v [4];
    bit           m_full;
    bit           m_ovr;
    int           m_ptr;

    demux_1to4 #(.W(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .D          (D),
        .sel        (sel),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .Y0         (Y0),
        .Y1         (Y1),
        .Y2         (Y2),
        .Y3         (Y3),
        .Y_valid    (Y_valid),
        .frame_valid(frame_valid),
        .frame_ack  (frame_ack),
        .ovr        (ovr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Apply one clock of the frame rules to the model, given this cycle's inputs.
    task automatic model_cycle(input bit r, input bit v, input logic [1:0] s,
                               input logic [W-1:0] d, input bit a);
        int ch;
        int filled;
        if (r) begin
            for (int i = 0; i < 4; i++) begin
                m_y[i] = '0;
                m_v[i] = 1'b0;
            end
            m_full = 1'b0;
            m_ovr  = 1'b0;
            m_ptr  = 0;
            return;
        end
        m_ovr = 1'b0;
        if (v && !m_full) begin
`ifdef DEMUX_AUTO_SEL_EN
            ch    = m_ptr;
            m_ptr = (m_ptr + 1) % 4;
`else
            ch = int'(s);
`endif
            if (m_v[ch]) m_ovr = 1'b1;
            m_y[ch] = d;
            m_v[ch] = 1'b1;
            filled = 0;
            for (int i = 0; i < 4; i++) filled += int'(m_v[i]);
            if (filled == 4) m_full = 1'b1;
        end else if (m_full && a) begin
            for (int i = 0; i < 4; i++) m_v[i] = 1'b0;
            m_full = 1'b0;
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, ":Y0"}, 32'(Y0), 32'(m_y[0]));
        check({tag, ":Y1"}, 32'(Y1), 32'(m_y[1]));
        check({tag, ":Y2"}, 32'(Y2), 32'(m_y[2]));
        check({tag, ":Y3"}, 32'(Y3), 32'(m_y[3]));
        check({tag, ":Y_valid"}, 32'(Y_valid), 32'({m_v[3], m_v[2], m_v[1], m_v[0]}));
        check({tag, ":frame_valid"}, 32'(frame_valid), 32'(m_full));
        check({tag, ":in_ready"}, 32'(in_ready), 32'(!m_full));
        check({tag, ":ovr"}, 32'(ovr), 32'(m_ovr));
    endtask

    // Drive inputs, advance one clock, then compare away from the edge.
    task automatic step(input string tag, input bit r, input bit v, input logic [1:0] s,
                        input logic [W-1:0] d, input bit a);
        rst       = r;
        in_valid  = v;
        sel       = s;
        D         = d;
        frame_ack = a;
        model_cycle(r, v, s, d, a);
        @(posedge clk);
        #1;
        compare_all(tag);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; sel = 2'd0; D = '0; frame_ack = 1'b0;

        // Reset with a valid symbol present: reset wins.
        step("reset", 1, 1, 2'd0, 2'b11, 0);
        check("reset_Y_valid", 32'(Y_valid), 32'h0);
        check("reset_in_ready", 32'(in_ready), 32'h1);

`ifdef DEMUX_AUTO_SEL_EN
        // Auto fill with sel held at 0.
        step("auto0", 0, 1, 2'd0, 2'b11, 0);
        step("auto1", 0, 1, 2'd0, 2'b10, 0);
        step("auto2", 0, 1, 2'd0, 2'b01, 0);
        step("auto3", 0, 1, 2'd0, 2'b00, 0);
        check("auto_Y0", 32'(Y0), 32'h3);
        check("auto_Y3", 32'(Y3), 32'h0);
        check("auto_frame", 32'(frame_valid), 32'h1);
        step("auto_ack", 0, 0, 2'd0, 2'b00, 1);
        step("auto_next", 0, 1, 2'd0, 2'b01, 0);
        check("auto_next_Y_valid", 32'(Y_valid), 32'h1);
        check("auto_next_Y0", 32'(Y0), 32'h1);
`else
        // Frame fill in sel mode.
        step("fill0", 0, 1, 2'd2, 2'b01, 0);
        check("fill0_Y_valid", 32'(Y_valid), 32'h4);
        step("fill1", 0, 1, 2'd0, 2'b10, 0);
        check("fill1_Y_valid", 32'(Y_valid), 32'h5);
        step("fill2", 0, 1, 2'd3, 2'b11, 0);
        check("fill2_Y_valid", 32'(Y_valid), 32'hd);
        step("fill3", 0, 1, 2'd1, 2'b00, 0);
        check("fill3_frame", 32'(frame_valid), 32'h1);
        check("fill3_Y0", 32'(Y0), 32'h2);
        check("fill3_Y2", 32'(Y2), 32'h1);

        // Backpressure: held symbol alongside ack is not written.
        step("bp_ack", 0, 1, 2'd0, 2'b01, 1);
        check("bp_ack_Y_valid", 32'(Y_valid), 32'h0);
        step("bp_take", 0, 1, 2'd0, 2'b01, 0);
        check("bp_take_Y_valid", 32'(Y_valid), 32'h1);

        // Overwrite on channel 1 (after a reset for a clean frame).
        step("ovr_rst", 1, 0, 2'd0, 2'b00, 0);
        step("ovr_w1", 0, 1, 2'd1, 2'b01, 0);
        step("ovr_w2", 0, 1, 2'd1, 2'b10, 0);
        check("ovr_pulse", 32'(ovr), 32'h1);
        check("ovr_Y1", 32'(Y1), 32'h2);
        step("ovr_idle", 0, 0, 2'd0, 2'b00, 0);
        check("ovr_one_cycle", 32'(ovr), 32'h0);

        // Mid-frame reset discards partial data.
        step("mid_rst", 1, 0, 2'd0, 2'b00, 0);
        step("mid0", 0, 1, 2'd0, 2'b01, 0);
        step("mid1", 0, 1, 2'd1, 2'b10, 0);
        step("mid2", 0, 1, 2'd2, 2'b11, 0);
        step("mid_rst2", 1, 1, 2'd3, 2'b11, 0);
        step("mid3", 0, 1, 2'd3, 2'b01, 0);
        step("mid4", 0, 1, 2'd2, 2'b01, 0);
        step("mid5", 0, 1, 2'd1, 2'b01, 0);
        check("mid5_no_frame", 32'(frame_valid), 32'h0);
        step("mid6", 0, 1, 2'd0, 2'b01, 0);
        check("mid6_frame", 32'(frame_valid), 32'h1);
`endif

        // Randomized traffic with occasional ack and rare reset.
        for (int n = 0; n < 400; n++) begin
            step("rand",
                 $urandom_range(99, 0) < 2,
                 $urandom_range(99, 0) < 70,
                 2'($urandom_range(3, 0)),
                 W'($urandom_range(3, 0)),
                 $urandom_range(99, 0) < 35);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/demux_1to4.md
# demux_1to4

Registered 1:4 demultiplexer with frame collection: the receive-side counterpart of the team's 4:1 selection mux. It accepts one W-bit symbol per handshake on a shared bus, steers it into one of four held output channels, and presents a complete frame once all four channels hold fresh data. Downstream logic acknowledges the frame to release the block for the next collection. It sits after a time-multiplexed link carrying D0..D3 over one bus.

## Interface
Parameters:
- W, default 2: symbol width per channel.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- D  in  W  incoming symbol.
- sel  in  2  destination channel (0..3); ignored when DEMUX_AUTO_SEL_EN is defined.
- in_valid  in  1  D/sel valid this cycle.
- in_ready  out  1  block can accept a symbol this cycle.
- Y0, Y1, Y2, Y3  out  W each  held channel outputs.
- Y_valid  out  4  bit n set when Yn holds data from the current frame.
- frame_valid  out  1  all four channels filled; frame held for downstream.
- frame_ack  in  1  downstream consumed the frame.
- ovr  out  1  one-cycle pulse: accepted write hit a channel already valid in this frame.

## Operation
- Accept = in_valid & in_ready.
- State machine, two states:
  - COLLECT: in_ready=1, frame_valid=0. On accept, Y[ch] <= D and Y_valid[ch] <= 1. When the accept completes Y_valid = 4'b1111, next state is FULL.
  - FULL: in_ready=0, frame_valid=1, Y0..Y3 stable. On frame_ack, Y_valid <= 0 and next state is COLLECT. Y0..Y3 keep their last values; only Y_valid is cleared.
- frame_ack in COLLECT is ignored: no state change and no clearing.
- Overwrite: an accept to a channel whose Y_valid bit is already 1 replaces Yn and pulses ovr for one cycle. Y_valid is unchanged.
- A 4th distinct-channel write completes the frame even if earlier writes overwrote. Completion is decided on Y_valid only.
- Channel ch is sel, or the internal pointer (see Configuration).
- in_valid with in_ready=0 is not accepted. The sender must hold it; the block does not buffer.

## Timing
- Reset values, from the edge where rst=1: state COLLECT, Y0..Y3=0, Y_valid=0, frame_valid=0, in_ready=1, ovr=0, pointer=0.
- Reset has priority over every other input in the same cycle. A reset mid-frame discards partial data.
- Write latency is 1 cycle: Yn and Y_valid update on the edge of the accept cycle.
- frame_valid rises on the edge that accepts the completing symbol, so it is visible the cycle after that accept. in_ready falls at the same edge.
- Ack turnaround: frame_ack is sampled at edge k. frame_valid=0 and in_ready=1 from cycle k+1. Minimum frame period is 4 accepts + 1 ack cycle = 5 cycles.
- in_valid in the same cycle as frame_ack is not accepted, because in_ready=0 in FULL.
- ovr asserts the cycle after the overwriting accept and lasts exactly 1 cycle.
- in_ready is a function of state only; there is no combinational path from in_valid.

## Configuration
- DEMUX_AUTO_SEL_EN defined:
  - ch comes from an internal 2-bit pointer. The pointer increments on every accept and wraps 3->0, and rst sets it to 0.
  - sel is ignored.
  - Symbols fill Y0, Y1, Y2, Y3 in order; ovr never asserts.
  - The pointer is 0 again at frame completion, so it is not reset by frame_ack.
- DEMUX_AUTO_SEL_EN undefined: ch = sel, and there is no pointer logic.

## Test plan
- Reset: assert rst with in_valid=1, D=2'b11 -> next cycle Y0..Y3=0, Y_valid=0, frame_valid=0, in_ready=1.
- Frame fill (sel mode): accepts (sel,D) = (2,01),(0,10),(3,11),(1,00) on consecutive cycles -> Y_valid steps 0100, 0101, 1101, 1111. frame_valid=1 and in_ready=0 the cycle after the 4th accept. Y0=10, Y1=00, Y2=01, Y3=11.
- Backpressure and ack: in FULL, hold in_valid=1 with D=01 and assert frame_ack for 1 cycle -> no write that cycle. Next cycle frame_valid=0, Y_valid=0, and the held symbol is accepted then.
- Overwrite: write sel=1 D=01, then sel=1 D=10 -> Y1=10, ovr high for exactly 1 cycle, Y_valid=0010, no frame.
- Mid-frame reset: after 3 accepts, pulse rst -> all outputs return to reset values. 4 new accepts are then required before frame_valid.
- With DEMUX_AUTO_SEL_EN: D = 11,10,01,00 with sel held at 0 -> Y0=11, Y1=10, Y2=01, Y3=00, frame_valid=1. After ack, the next D=01 lands in Y0.
